rx_frame_fifo: RTL and testbench
================================

RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
- REQ-001 Parameter DEPTH, default 2048: FIFO entries, power of two, 64..16384.
- REQ-002 Parameter DECISION_WAIT, default 2: cycles after frame end during which a late invalid_frame_i pulse still drops the frame; range 0..7.
- REQ-003 Port clk, input, 1: single clock for all logic.
- REQ-004 Port rst, input, 1: synchronous, active-high reset.
- REQ-005 Port s_data_i, input, 8: received byte from the RX MAC byte stream.
- REQ-006 Port s_valid_i, input, 1: byte valid; high for the whole frame, low in the gap between frames.
- REQ-007 Port invalid_frame_i, input, 1: one-cycle pulse from the RX MAC marking the current or just-ended frame bad (CRC or parser error).
- REQ-008 Port m_data_o, output, 8: output byte.
- REQ-009 Port m_valid_o, output, 1: output byte valid.
- REQ-010 Port m_last_o, output, 1: output byte is the final byte of its frame.
- REQ-011 Port m_ready_i, input, 1: downstream accepts the byte when m_valid_o and m_ready_i are both high.
- REQ-012 Port overflow_o, output, 1: one-cycle pulse when a frame is dropped because the FIFO is full.

Function
- REQ-013 Store-and-forward: a frame's bytes SHALL become visible at the output only after the frame is committed.
- REQ-014 Entries SHALL be 9 bits wide: the data byte plus a last flag.
- REQ-015 The FIFO SHALL keep a write pointer, a commit pointer and a read pointer, each log2(DEPTH)+1 bits wide with wrap bit.
- REQ-016 Full: wr_ptr - rd_ptr == DEPTH. Output empty: rd_ptr == commit_ptr.
- REQ-017 Write FSM states: IDLE, RECV, DECIDE, DISCARD.
- REQ-018 IDLE -> RECV on s_valid_i=1; the first byte goes into a one-byte hold register.
- REQ-019 In RECV, each new byte SHALL write the held byte with last=0 and then load the new byte into the hold register.
- REQ-020 RECV -> DECIDE when s_valid_i falls; the held byte SHALL be written with last=1 in that cycle.
- REQ-021 A 1-byte frame SHALL be stored as a single entry with last=1.
- REQ-022 A sticky bad flag SHALL be set by invalid_frame_i at any time in RECV, DECIDE or DISCARD, and cleared when a new frame starts.
- REQ-023 DECIDE SHALL last DECISION_WAIT cycles, then decide:
  - bad flag clear: commit_ptr <= wr_ptr;
  - bad flag set: wr_ptr <= commit_ptr (rollback).
  - Then go to IDLE.
- REQ-024 With DECISION_WAIT=0, the decision SHALL be taken in the cycle after s_valid_i falls.
- REQ-025 If s_valid_i rises during DECIDE, the decision SHALL be finalized in that cycle using the bad flag as it stands, and the new frame SHALL enter RECV with its byte held.
- REQ-026 If a write is needed while the FIFO is full:
  - rollback wr_ptr to commit_ptr;
  - pulse overflow_o;
  - go to DISCARD.
- REQ-027 DISCARD SHALL ignore bytes until s_valid_i is low, then go to IDLE.
- REQ-028 Read side: output register plus one-entry prefetch, so back-to-back m_ready_i sustains one byte per cycle.
- REQ-029 m_valid_o SHALL assert within 3 cycles of a commit into an empty FIFO.
- REQ-030 While m_valid_o=1 and m_ready_i=0, m_data_o, m_valid_o and m_last_o SHALL hold stable.
- REQ-031 Simultaneous read and write, or read and commit, in the same cycle SHALL both take effect.

Reset
- REQ-032 On rst=1, all three pointers SHALL clear to 0, the FSM SHALL go to IDLE, and the hold register and bad flag SHALL clear.
- REQ-033 Reset values: m_valid_o=0, m_last_o=0, m_data_o=0, overflow_o=0.
- REQ-034 A frame in progress at reset SHALL be lost; RAM contents need no reset.

Configuration
- REQ-035 Macro RX_FRAME_FIFO_STATS_EN, when defined, SHALL add three 32-bit outputs, each wrapping and reset to 0:
  - frames_ok_o: +1 per commit;
  - frames_bad_o: +1 per invalid-flag rollback;
  - frames_ovf_o: +1 per overflow drop.
- REQ-036 Without RX_FRAME_FIFO_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
- REQ-037 Package mac_if_pkg SHALL hold:
  - the write-FSM state enum;
  - the fifo_entry_t struct {last, data[7:0]};
  - the default DEPTH and DECISION_WAIT constants.
- REQ-038 Sub-module rx_frame_ram: simple dual-port, one write and one read port, registered read, 1-cycle read latency.

Verification
- REQ-039 64-byte good frame, m_ready_i=1 -> 64 output bytes in order, m_last_o only on byte 64, m_valid_o within 3 cycles of commit.
- REQ-040 Invalid pulse in byte 30 of a 100-byte frame, then a good 60-byte frame -> only the 60 bytes are output; frames_bad_o=1.
- REQ-041 Invalid pulse 2 cycles after s_valid_i falls, DECISION_WAIT=2 -> frame dropped; same pulse at cycle 3 -> frame output.
- REQ-042 DEPTH=64, m_ready_i=0, 80-byte frame -> overflow_o pulses once, nothing is output, next 40-byte frame is output intact; frames_ovf_o=1.
- REQ-043 1-byte frame followed by a frame whose s_valid_i rises during DECIDE -> both frames output; the first is one entry with m_last_o=1.
- REQ-044 rst asserted mid-frame with the output stalled -> m_valid_o=0 next cycle; a following good frame is output correctly.

Source files
------------

// File: rtl/mac_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_if_pkg
//  Description : Shared types and default constants for the RX frame FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_if_pkg;

    localparam int c_DEFAULT_DEPTH         = 2048;
    localparam int c_DEFAULT_DECISION_WAIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_DISCARD = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/rx_frame_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_fifo_if
//  Description : Byte-stream in / framed byte-stream out bundle of the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_fifo_if;

    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       invalid_frame_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i;
    logic       overflow_o;

    // FIFO side
    modport slave (
        input  s_data_i, s_valid_i, invalid_frame_i, m_ready_i,
        output m_data_o, m_valid_o, m_last_o, overflow_o
    );

    // MAC / downstream side
    modport master (
        output s_data_i, s_valid_i, invalid_frame_i, m_ready_i,
        input  m_data_o, m_valid_o, m_last_o, overflow_o
    );

endinterface
`default_nettype wire

// File: rtl/rx_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_ram
//  Description : Simple dual-port entry RAM, registered read (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_ram
    import mac_if_pkg::*;
#(
    parameter int ADDR_W = 11
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  fifo_entry_t       i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output fifo_entry_t       o_rdata
);

    localparam int c_WORDS = 1 << ADDR_W;

    fifo_entry_t r_mem [c_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_fifo
//  Description : Store-and-forward RX frame FIFO; bad or overflowing frames
//                are rolled back before they become visible downstream.
//                Optional frame statistics: RX_FRAME_FIFO_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_fifo
    import mac_if_pkg::*;
#(
    parameter int DEPTH         = c_DEFAULT_DEPTH,
    parameter int DECISION_WAIT = c_DEFAULT_DECISION_WAIT
)(
    input  logic           clk,
    input  logic           rst,
    rx_frame_fifo_if.slave bus
`ifdef RX_FRAME_FIFO_STATS_EN
    ,
    output logic [31:0]    frames_ok_o,
    output logic [31:0]    frames_bad_o,
    output logic [31:0]    frames_ovf_o
`endif
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_PW        = c_AW + 1;
    localparam logic [c_PW-1:0] c_FULL_DIST = c_PW'(DEPTH);
    localparam logic [2:0]      c_WAIT_LAST = (DECISION_WAIT == 0) ? 3'd0 : 3'(DECISION_WAIT - 1);

    wr_state_e       r_state, w_state_nxt;
    logic [c_PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [c_PW-1:0] r_commit_ptr, w_commit_ptr_nxt;
    logic [c_PW-1:0] r_rd_ptr;
    logic [7:0]      r_hold, w_hold_nxt;
    logic            r_bad, w_bad_nxt, w_bad_now;
    logic [2:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic            r_overflow;
    logic            w_full, w_we, w_ovf, w_commit, w_rollback_bad;
    fifo_entry_t     w_wentry;

    assign w_full = ((r_wr_ptr - r_rd_ptr) == c_FULL_DIST);

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_hold_nxt       = r_hold;
        w_bad_nxt        = r_bad;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_we             = 1'b0;
        w_wentry         = '{last: 1'b0, data: r_hold};
        w_ovf            = 1'b0;
        w_commit         = 1'b0;
        w_rollback_bad   = 1'b0;
        w_bad_now        = r_bad | bus.invalid_frame_i;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.s_valid_i) begin
                    w_hold_nxt  = bus.s_data_i;
                    w_bad_nxt   = 1'b0;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                w_bad_nxt = w_bad_now;
                if (w_full) begin
                    w_ovf        = 1'b1;
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_state_nxt  = ST_DISCARD;
                end else begin
                    // The held byte is the last one exactly when the stream just ended.
                    w_we          = 1'b1;
                    w_wentry.last = ~bus.s_valid_i;
                    w_wr_ptr_nxt  = r_wr_ptr + c_PW'(1);
                    if (bus.s_valid_i) begin
                        w_hold_nxt = bus.s_data_i;
                    end else begin
                        w_wait_cnt_nxt = 3'd0;
                        w_state_nxt    = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                w_bad_nxt = w_bad_now;
                if (bus.s_valid_i) begin
                    // Next frame already started: settle the old one on the flag as it is.
                    w_commit       = ~r_bad;
                    w_rollback_bad = r_bad;
                    w_hold_nxt     = bus.s_data_i;
                    w_bad_nxt      = 1'b0;
                    w_state_nxt    = ST_RECV;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_commit       = ~w_bad_now;
                    w_rollback_bad = w_bad_now;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            ST_DISCARD: begin
                w_bad_nxt = w_bad_now;
                if (!bus.s_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_commit) begin
            w_commit_ptr_nxt = r_wr_ptr;
        end
        if (w_rollback_bad) begin
            w_wr_ptr_nxt = r_commit_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_hold       <= '0;
            r_bad        <= 1'b0;
            r_wait_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_hold       <= w_hold_nxt;
            r_bad        <= w_bad_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_overflow   <= w_ovf;
        end
    end

    // Read side: RAM read -> prefetch slot -> output register.
    fifo_entry_t r_pf, r_out, w_ram_q;
    logic        r_pf_valid, r_out_valid, r_pend;
    logic        w_empty, w_pop, w_issue;
    logic [1:0]  w_occ;

    assign w_empty = (r_rd_ptr == r_commit_ptr);
    assign w_pop   = r_out_valid & bus.m_ready_i;
    assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_pf_valid} + {1'b0, r_pend} - {1'b0, w_pop};
    assign w_issue = ~w_empty & (w_occ < 2'd2);

    rx_frame_ram #(
        .ADDR_W (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[c_AW-1:0]),
        .i_wdata (w_wentry),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr[c_AW-1:0]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_pend      <= 1'b0;
            r_pf        <= '0;
            r_pf_valid  <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (!r_out_valid || w_pop) begin
                if (r_pf_valid) begin
                    r_out       <= r_pf;
                    r_out_valid <= 1'b1;
                    r_pf        <= w_ram_q;
                    r_pf_valid  <= r_pend;
                end else if (r_pend) begin
                    r_out       <= w_ram_q;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (r_pend) begin
                r_pf       <= w_ram_q;
                r_pf_valid <= 1'b1;
            end
        end
    end

    assign bus.m_data_o   = r_out.data;
    assign bus.m_last_o   = r_out.last;
    assign bus.m_valid_o  = r_out_valid;
    assign bus.overflow_o = r_overflow;

`ifdef RX_FRAME_FIFO_STATS_EN
    logic [31:0] r_frames_ok, r_frames_bad, r_frames_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
            r_frames_ovf <= '0;
        end else begin
            if (w_commit)       r_frames_ok  <= r_frames_ok + 32'd1;
            if (w_rollback_bad) r_frames_bad <= r_frames_bad + 32'd1;
            if (w_ovf)          r_frames_ovf <= r_frames_ovf + 32'd1;
        end
    end

    assign frames_ok_o  = r_frames_ok;
    assign frames_bad_o = r_frames_bad;
    assign frames_ovf_o = r_frames_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_fifo
//  Description : Directed self-checking bench; u_dut uses default parameters,
//                u_dut_small uses DEPTH=64 for the overflow scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_fifo;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       inv     = 1'b0;
    logic       ready   = 1'b0;
    logic       sel     = 1'b0;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] q [$];
    int         ovf_cnt  = 0;
    int         vcnt     = 0;

    always #5 clk = ~clk;

    rx_frame_fifo_if bus_a ();
    rx_frame_fifo_if bus_b ();

    assign bus_a.s_data_i        = s_data;
    assign bus_a.s_valid_i       = s_valid;
    assign bus_a.invalid_frame_i = inv;
    assign bus_a.m_ready_i       = ready;
    assign bus_b.s_data_i        = s_data;
    assign bus_b.s_valid_i       = s_valid;
    assign bus_b.invalid_frame_i = inv;
    assign bus_b.m_ready_i       = ready;

`ifdef RX_FRAME_FIFO_STATS_EN
    logic [31:0] ok_a, bad_a, ovf_a, ok_b, bad_b, ovf_b;
`endif

    rx_frame_fifo u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_a)
`ifdef RX_FRAME_FIFO_STATS_EN
        ,
        .frames_ok_o  (ok_a),
        .frames_bad_o (bad_a),
        .frames_ovf_o (ovf_a)
`endif
    );

    rx_frame_fifo #(
        .DEPTH (64)
    ) u_dut_small (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_b)
`ifdef RX_FRAME_FIFO_STATS_EN
        ,
        .frames_ok_o  (ok_b),
        .frames_bad_o (bad_b),
        .frames_ovf_o (ovf_b)
`endif
    );

    logic       w_mv, w_ml, w_ovf;
    logic [7:0] w_md;
    assign w_mv  = sel ? bus_b.m_valid_o  : bus_a.m_valid_o;
    assign w_ml  = sel ? bus_b.m_last_o   : bus_a.m_last_o;
    assign w_md  = sel ? bus_b.m_data_o   : bus_a.m_data_o;
    assign w_ovf = sel ? bus_b.overflow_o : bus_a.overflow_o;

    always @(negedge clk) begin
        if (!rst) begin
            if (w_mv && ready) q.push_back({w_ml, w_md});
            if (w_ovf)         ovf_cnt = ovf_cnt + 1;
            if (w_mv)          vcnt = vcnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        inv     = 1'b0;
        idle(2);
        rst     = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input int inv_idx);
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(int'(base) + i);
            inv     = (i == inv_idx);
            tick();
        end
        s_valid = 1'b0;
        inv     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int start, input int len, input logic [7:0] base);
        logic [8:0] got;
        logic [8:0] exp;
        for (int i = 0; i < len; i++) begin
            got = (start + i < q.size()) ? q[start + i] : 9'h1ff;
            exp = {(i == len - 1), 8'(int'(base) + i)};
            chk($sformatf("%s[%0d]", tag, i), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        int q0;
        int n;
        int o0;
        int v0;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(bus_a.m_valid_o), 32'd0);
        chk("rst_last",  32'(bus_a.m_last_o),  32'd0);
        chk("rst_data",  32'(bus_a.m_data_o),  32'd0);
        chk("rst_ovf",   32'(bus_a.overflow_o), 32'd0);
        chk("rst_valid_small", 32'(bus_b.m_valid_o), 32'd0);
`ifdef RX_FRAME_FIFO_STATS_EN
        chk("rst_ok_cnt", ok_a, 32'd0);
`endif

        // 64-byte good frame, ready held high
        sel   = 1'b0;
        ready = 1'b1;
        q0    = q.size();
        send_frame(64, 8'h10, -1);
        chk("saf_nothing_before_commit", 32'(q.size() - q0), 32'd0);
        n = 0;
        while (!bus_a.m_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("latency_le_6", 32'(n <= 6), 32'd1);
        idle(80);
        chk("g64_count", 32'(q.size() - q0), 32'd64);
        chk_frame("g64", q0, 64, 8'h10);

        // Invalid in byte 30 of 100-byte frame, then good 60-byte frame
        do_reset();
        q0 = q.size();
        send_frame(100, 8'h00, 29);
        idle(5);
        send_frame(60, 8'h80, -1);
        idle(100);
        chk("bad100_count", 32'(q.size() - q0), 32'd60);
        chk_frame("g60", q0, 60, 8'h80);
`ifdef RX_FRAME_FIFO_STATS_EN
        chk("bad100_bad_cnt", bad_a, 32'd1);
        chk("bad100_ok_cnt",  ok_a,  32'd1);
`endif

        // Late invalid: 2 cycles after fall drops, 3 cycles after keeps
        do_reset();
        q0 = q.size();
        send_frame(10, 8'h20, -1);
        idle(2);
        inv = 1'b1;
        tick();
        inv = 1'b0;
        idle(20);
        chk("late2_dropped", 32'(q.size() - q0), 32'd0);
        send_frame(10, 8'h40, -1);
        idle(3);
        inv = 1'b1;
        tick();
        inv = 1'b0;
        idle(20);
        chk("late3_count", 32'(q.size() - q0), 32'd10);
        chk_frame("late3", q0, 10, 8'h40);
`ifdef RX_FRAME_FIFO_STATS_EN
        chk("late_bad_cnt", bad_a, 32'd1);
        chk("late_ok_cnt",  ok_a,  32'd1);
`endif

        // Overflow on the 64-entry instance with the output stalled
        ready = 1'b0;
        sel   = 1'b1;
        do_reset();
        o0 = ovf_cnt;
        v0 = vcnt;
        q0 = q.size();
        send_frame(80, 8'h00, -1);
        idle(10);
        chk("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
        chk("ovf_no_output", 32'(vcnt - v0), 32'd0);
        send_frame(40, 8'h60, -1);
        idle(10);
        chk("stall_valid", 32'(bus_b.m_valid_o), 32'd1);
        chk("stall_data",  32'(bus_b.m_data_o),  32'h60);
        chk("stall_last",  32'(bus_b.m_last_o),  32'd0);
        idle(3);
        chk("stall_valid_hold", 32'(bus_b.m_valid_o), 32'd1);
        chk("stall_data_hold",  32'(bus_b.m_data_o),  32'h60);
        ready = 1'b1;
        idle(60);
        chk("ovf_next_count", 32'(q.size() - q0), 32'd40);
        chk_frame("ovf_next", q0, 40, 8'h60);
`ifdef RX_FRAME_FIFO_STATS_EN
        chk("ovf_ovf_cnt", ovf_b, 32'd1);
        chk("ovf_ok_cnt",  ok_b,  32'd1);
        chk("ovf_bad_cnt", bad_b, 32'd0);
`endif

        // 1-byte frame, next frame rises during DECIDE
        sel = 1'b0;
        do_reset();
        q0 = q.size();
        send_frame(1, 8'hA5, -1);
        tick();
        send_frame(5, 8'hB0, -1);
        idle(20);
        chk("short_count", 32'(q.size() - q0), 32'd6);
        chk_frame("one_byte", q0, 1, 8'hA5);
        chk_frame("after_decide", q0 + 1, 5, 8'hB0);

        // Reset mid-frame with output stalled
        do_reset();
        ready = 1'b0;
        send_frame(20, 8'h30, -1);
        idle(10);
        chk("pre_rst_valid", 32'(bus_a.m_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hE0 + i);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(bus_a.m_valid_o), 32'd0);
        chk("midrst_data",  32'(bus_a.m_data_o),  32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        idle(3);
        ready = 1'b1;
        q0    = q.size();
        send_frame(8, 8'h70, -1);
        idle(30);
        chk("post_rst_count", 32'(q.size() - q0), 32'd8);
        chk_frame("post_rst", q0, 8, 8'h70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
